rf_writeback_queue: RTL

//  Write-side initiator for the 32x32 register file. Accepts write-back

---
 rtl/rf_writeback_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rf_writeback_queue.sv
// Write-back queue feeding the 32x32 register file write port from the ALU and LSU.
// Latency: accepted at edge N -> rf_we during cycle N+1 -> regfile updated at edge N+1.
// Backpressure: ready drops only when the queue is full or in reset; LSU beats the ALU.
module rf_writeback_queue #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   byp_addr1,
    output logic            byp_hit1,
    output logic [XLEN-1:0] byp_data1,
    input  logic [AW-1:0]   byp_addr2,
    output logic            byp_hit2,
    output logic [XLEN-1:0] byp_data2,
    output logic            idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]   rd_mem_q   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic            full;
    logic            empty;
    logic            lsu_fire;
    logic            alu_fire;
    logic            enq;
    logic            deq;
    logic [AW-1:0]   enq_rd;
    logic [XLEN-1:0] enq_data;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Ready ignores a same-cycle drain so the handshake never depends on the dequeue path.
    assign lsu_ready = !rst && !full;
    assign alu_ready = !rst && !full && !lsu_valid;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_fire  = alu_valid && alu_ready;

    // Select the accepted source; writes to x0 complete the handshake but are dropped.
    always_comb begin
        enq_rd   = alu_rd;
        enq_data = alu_data;
        if (lsu_fire) begin
            enq_rd   = lsu_rd;
            enq_data = lsu_data;
        end
        enq = (lsu_fire || alu_fire) && (enq_rd != '0);
    end

    // The regfile consumes the head entry every cycle the queue is non-empty.
    assign deq      = !empty;
    assign rf_we    = !empty;
    assign rf_waddr = rd_mem_q[head_q];
    assign rf_wdata = data_mem_q[head_q];
    assign idle     = empty;

    // Pointer and occupancy next state; simultaneous push and pop leave count unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + 1'b1;
        end
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset discards everything still queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; no reset needed since occupancy alone qualifies every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem_q[tail_q]   <= enq_rd;
            data_mem_q[tail_q] <= enq_data;
        end
    end

    // Bypass search from head to tail so the youngest match overwrites older ones.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((byp_addr1 != '0) && (rd_mem_q[head_q + PW'(i)] == byp_addr1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_mem_q[head_q + PW'(i)];
                end
                if ((byp_addr2 != '0) && (rd_mem_q[head_q + PW'(i)] == byp_addr2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_mem_q[head_q + PW'(i)];
                end
            end
        end
    end

endmodule
